or_tree_pipe: RTL and testbench

//  Parametrised, pipelined bitwise-OR reduction of N_IN W-bit channels.

---
 rtl/or_tree_pkg.sv | 23 ++
 rtl/or_tree_stage.sv | 43 ++++
 rtl/or_tree_pipe.sv | 90 +++++++++
 tb/tb_or_tree_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or_tree_pkg.sv
// Shared helpers for the pipelined OR reduction tree: tree depth and padded
// leaf count derived from the channel fan-in.
package or_tree_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // A single register stage is still needed for one or two channels.
    function automatic int unsigned tree_levels(input int unsigned n_in);
        return (n_in <= 2) ? 1 : clog2(n_in);
    endfunction

    function automatic int unsigned pad_leaves(input int unsigned n_in);
        return 32'd1 << tree_levels(n_in);
    endfunction

endpackage

// File: rtl/or_tree_stage.sv
// One tree level: pairwise OR of N_OPS operands into registered results,
// with a valid flop and a load enable that lets bubbles collapse.
module or_tree_stage #(
    parameter int unsigned W     = 8,
    parameter int unsigned N_OPS = 2,
    localparam int unsigned N_RES = (N_OPS + 1) / 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [N_OPS*W-1:0]   in_data,
    input  logic                 in_valid,
    input  logic                 en_next,
    output logic                 load_en_c,
    output logic [N_RES*W-1:0]   out_data,
    output logic                 out_valid
);

    logic [2*N_RES*W-1:0] ops;
    logic [N_RES*W-1:0]   or_c;

    // An unpaired last operand is ORed with the zero extension.
    always_comb begin
        ops  = (2*N_RES*W)'(in_data);
        or_c = '0;
        for (int unsigned r = 0; r < N_RES; r++) begin
            or_c[r*W +: W] = ops[2*r*W +: W] | ops[(2*r+1)*W +: W];
        end
    end

    assign load_en_c = !out_valid | en_next;

    // Data only moves with a real beat so an empty stage keeps its stale value.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_en_c) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= or_c;
        end
    end

endmodule

// File: rtl/or_tree_pipe.sv
// Pipelined bitwise-OR reduction of N_IN W-bit channels with valid/ready flow.
// Define OR_STICKY_EN to add the acc_clr/out_sticky result accumulator.
module or_tree_pipe
    import or_tree_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned N_IN = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [N_IN*W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef OR_STICKY_EN
    ,
    input  logic              acc_clr,
    output logic [W-1:0]      out_sticky
`endif
);

    localparam int unsigned LEVELS = tree_levels(N_IN);
    localparam int unsigned PAD    = pad_leaves(N_IN);

    logic [PAD*W-1:0] in_pad;
    assign in_pad = (PAD*W)'(in_data);

    for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
        localparam int unsigned N_OPS = PAD >> s;
        localparam int unsigned N_RES = N_OPS / 2;

        logic [N_OPS*W-1:0] stg_in;
        logic               stg_in_valid;
        logic               en_next;
        logic               load_en;
        logic [N_RES*W-1:0] stg_out;
        logic               stg_valid;

        if (s == 0) begin : g_first
            assign stg_in       = in_pad;
            assign stg_in_valid = in_valid;
        end else begin : g_mid
            assign stg_in       = g_lvl[s-1].stg_out;
            assign stg_in_valid = g_lvl[s-1].stg_valid;
        end

        if (s == LEVELS - 1) begin : g_last
            assign en_next = out_ready;
        end else begin : g_inner
            assign en_next = g_lvl[s+1].load_en;
        end

        or_tree_stage #(
            .W     (W),
            .N_OPS (N_OPS)
        ) u_stage (
            .clk       (clk),
            .reset_L   (reset_L),
            .in_data   (stg_in),
            .in_valid  (stg_in_valid),
            .en_next   (en_next),
            .load_en_c (load_en),
            .out_data  (stg_out),
            .out_valid (stg_valid)
        );
    end

    assign in_ready  = g_lvl[0].load_en;
    assign out_data  = g_lvl[LEVELS-1].stg_out;
    assign out_valid = g_lvl[LEVELS-1].stg_valid;

`ifdef OR_STICKY_EN
    logic out_hs_c;
    assign out_hs_c = out_valid & out_ready;

    // Clear beats the accumulated history but keeps a coincident result.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_sticky <= '0;
        end else if (acc_clr) begin
            out_sticky <= out_hs_c ? out_data : '0;
        end else if (out_hs_c) begin
            out_sticky <= out_sticky | out_data;
        end
    end
`endif

endmodule

// File: tb/tb_or_tree_pipe.sv
// Directed self-checking bench for or_tree_pipe (N_IN=4, 3 and 1 instances).
module tb_or_tree_pipe;

    logic        clk;
    logic        reset_L;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  out_data3;
    logic        out_valid3;

    logic [7:0]  in_data1;
    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  out_data1;
    logic        out_valid1;

`ifdef OR_STICKY_EN
    logic        acc_clr;
    logic [7:0]  out_sticky;
    logic [7:0]  out_sticky3;
    logic [7:0]  out_sticky1;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;

    or_tree_pipe #(.W(8), .N_IN(4)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef OR_STICKY_EN
        ,
        .acc_clr    (acc_clr),
        .out_sticky (out_sticky)
`endif
    );

    or_tree_pipe #(.W(8), .N_IN(3)) dut3 (
        .clk       (clk),
        .reset_L   (reset_L),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (1'b1)
`ifdef OR_STICKY_EN
        ,
        .acc_clr    (1'b0),
        .out_sticky (out_sticky3)
`endif
    );

    or_tree_pipe #(.W(8), .N_IN(1)) dut1 (
        .clk       (clk),
        .reset_L   (reset_L),
        .in_data   (in_data1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .out_data  (out_data1),
        .out_valid (out_valid1),
        .out_ready (1'b1)
`ifdef OR_STICKY_EN
        ,
        .acc_clr    (1'b0),
        .out_sticky (out_sticky1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time budget expired");
        $fatal(1);
    end

    initial begin
        reset_L   = 1'b0;
        in_data   = 32'hFFFF_FFFF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data3  = 24'h0;
        in_valid3 = 1'b0;
        in_data1  = 8'h0;
        in_valid1 = 1'b0;
`ifdef OR_STICKY_EN
        acc_clr   = 1'b0;
`endif

        // Reset held with in_valid high
        adv(); adv();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid3", 32'(out_valid3), 32'd0);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);
`ifdef OR_STICKY_EN
        chk("rst_sticky", 32'(out_sticky), 32'h00);
`endif
        adv();
        reset_L  = 1'b1;
        in_valid = 1'b0;

        // Two-beat stream, out_ready high
        in_data   = 32'h0804_0201;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        adv();
        in_data = 32'h0000_0080;
        @(negedge clk);
        chk("stream_lat1_valid", 32'(out_valid), 32'd0);
        adv();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_b1_valid", 32'(out_valid), 32'd1);
        chk("stream_b1_data",  32'(out_data),  32'h0F);
        adv();
        @(negedge clk);
        chk("stream_b2_valid", 32'(out_valid), 32'd1);
        chk("stream_b2_data",  32'(out_data),  32'h80);
        adv();
        @(negedge clk);
        chk("stream_idle_valid", 32'(out_valid), 32'd0);
        chk("stream_stale_data", 32'(out_data),  32'h80);

        // Stall: fill with out_ready low for 5 cycles
        adv();
        out_ready = 1'b0;
        in_data   = 32'h0000_0011;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("stall_ready_empty", 32'(in_ready), 32'd1);
        adv();
        in_data = 32'h2200_0000;
        @(negedge clk);
        chk("stall_ready_half", 32'(in_ready), 32'd1);
        adv();
        in_data = 32'h0033_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_held_data", 32'(out_data),  32'h11);
            if (i < 4) adv();
        end
        adv();
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        adv();
        in_data = 32'h0000_4400;
        @(negedge clk);
        chk("release_b2_data", 32'(out_data), 32'h22);
        adv();
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_b3_data",  32'(out_data),  32'h33);
        chk("release_b3_valid", 32'(out_valid), 32'd1);
        adv();
        @(negedge clk);
        chk("release_b4_data",  32'(out_data),  32'h44);
        chk("release_b4_valid", 32'(out_valid), 32'd1);
        adv();
        @(negedge clk);
        chk("release_drained", 32'(out_valid), 32'd0);

        // Odd fan-in and single channel
        adv();
        in_data3  = 24'h00_0F_F0;
        in_valid3 = 1'b1;
        in_data1  = 8'hA5;
        in_valid1 = 1'b1;
        adv();
        in_valid3 = 1'b0;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("n1_valid",  32'(out_valid1), 32'd1);
        chk("n1_data",   32'(out_data1),  32'hA5);
        chk("n3_lat1",   32'(out_valid3), 32'd0);
        adv();
        @(negedge clk);
        chk("n3_valid",  32'(out_valid3), 32'd1);
        chk("n3_data",   32'(out_data3),  32'hFF);
        chk("n1_done",   32'(out_valid1), 32'd0);

        // Async reset with two beats in flight
        adv();
        in_data  = 32'h0000_0001;
        in_valid = 1'b1;
        adv();
        in_data = 32'h0000_0002;
        adv();
        in_valid = 1'b0;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        reset_L = 1'b0;
        #1;
        chk("async_rst_valid",    32'(out_valid), 32'd0);
        chk("async_rst_data",     32'(out_data),  32'h00);
        chk("async_rst_in_ready", 32'(in_ready),  32'd1);
        adv();
        reset_L  = 1'b1;
        in_data  = 32'h0000_0040;
        in_valid = 1'b1;
        adv();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_no_ghost", 32'(out_valid), 32'd0);
        adv();
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data",  32'(out_data),  32'h40);
        adv();
        @(negedge clk);
        chk("post_rst_drain", 32'(out_valid), 32'd0);

`ifdef OR_STICKY_EN
        // Sticky accumulator: clear, accumulate, clear-with-handshake
        adv();
        acc_clr = 1'b1;
        adv();
        acc_clr = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", 32'(out_sticky), 32'h00);
        adv();
        in_data  = 32'h0000_0001;
        in_valid = 1'b1;
        adv();
        in_data = 32'h0000_0010;
        adv();
        in_data = 32'h0000_0080;
        adv();
        in_valid = 1'b0;
        adv();
        adv();
        @(negedge clk);
        chk("sticky_accum", 32'(out_sticky), 32'h91);
        adv();
        in_data  = 32'h0000_0004;
        in_valid = 1'b1;
        adv();
        in_valid = 1'b0;
        adv();
        acc_clr = 1'b1;
        @(negedge clk);
        chk("sticky_clr_beat_valid", 32'(out_valid), 32'd1);
        adv();
        acc_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr_hs", 32'(out_sticky), 32'h04);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
